// File: rtl/mio_pkg.sv
// Shared types for the MIO two-master arbiter: FSM state encoding and master indices.
package mio_pkg;

  typedef enum logic [1:0] {
    MIO_IDLE = 2'd0,
    MIO_BUS  = 2'd1,
    MIO_ACK  = 2'd2
  } mio_state_e;

  localparam logic MIO_M_CPU = 1'b0;
  localparam logic MIO_M_DMA = 1'b1;

endpackage

// File: rtl/mio_arbiter_if.sv
// Master-side handshakes and decoder-side bus of the MIO arbiter, bundled as one interface.
interface mio_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [31:0] mem_a;
  logic [31:0] d_t_mem;
  logic        wmem;
  logic        rmem;
  logic [31:0] d_f_mem;

  logic        owner;
  logic        busy;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  d_f_mem,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_a, d_t_mem, wmem, rmem, owner, busy
  );

  // Masters plus decoder, as seen from outside the arbiter
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output d_f_mem,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_a, d_t_mem, wmem, rmem, owner, busy
  );
endinterface

// File: rtl/mio_arbiter.sv
// Two-master MIO bus arbiter: CPU has fixed priority, a starvation counter forces DMA progress.
// Each access holds the bus WAIT_CYCLES cycles, then pulses a one-cycle ack with read data.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MAX_STARVE  = 8
) (
  input  logic          clk,
  input  logic          rst,
  mio_arbiter_if.slave  bus_io
);

  localparam int unsigned CntW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned StarveW = $clog2(MAX_STARVE + 1);
  localparam logic [CntW-1:0]    CntLoad   = CntW'(WAIT_CYCLES - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_STARVE);

  mio_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [31:0]        rdata_q, rdata_d;

  logic any_req;
  logic win_dma;
  logic cur_we;

  assign any_req = bus_io.m0_req | bus_io.m1_req;
  // DMA wins when alone, or when it has lost MAX_STARVE arbitrations in a row
  assign win_dma = bus_io.m1_req & (~bus_io.m0_req | (starve_q == StarveMax));
  assign cur_we  = (owner_q == MIO_M_DMA) ? bus_io.m1_we : bus_io.m0_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MIO_IDLE;
      owner_q  <= MIO_M_CPU;
      cnt_q    <= '0;
      starve_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      MIO_IDLE: begin
        if (!bus_io.m1_req) begin
          starve_d = '0;
        end
        if (any_req) begin
          owner_d = win_dma ? MIO_M_DMA : MIO_M_CPU;
          cnt_d   = CntLoad;
          state_d = MIO_BUS;
          if (win_dma) begin
            starve_d = '0;
          end else if (bus_io.m1_req && (starve_q != StarveMax)) begin
            starve_d = starve_q + StarveW'(1);
          end
        end
      end
      MIO_BUS: begin
        if (cnt_q == '0) begin
          rdata_d = bus_io.d_f_mem;
          state_d = MIO_ACK;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      MIO_ACK: begin
        state_d = MIO_IDLE;
      end
      default: begin
        state_d = MIO_IDLE;
      end
    endcase
  end

  always_comb begin
    bus_io.mem_a    = '0;
    bus_io.d_t_mem  = '0;
    bus_io.wmem     = 1'b0;
    bus_io.rmem     = 1'b0;
    bus_io.m0_ack   = 1'b0;
    bus_io.m1_ack   = 1'b0;
    bus_io.m0_rdata = '0;
    bus_io.m1_rdata = '0;
    if (state_q == MIO_BUS) begin
      bus_io.mem_a   = (owner_q == MIO_M_DMA) ? bus_io.m1_addr : bus_io.m0_addr;
      bus_io.d_t_mem = (owner_q == MIO_M_DMA) ? bus_io.m1_wdata : bus_io.m0_wdata;
      bus_io.rmem    = ~cur_we;
      // Single write strobe, in the last bus cycle only
      bus_io.wmem    = cur_we & (cnt_q == '0);
    end
    if (state_q == MIO_ACK) begin
      bus_io.m0_ack   = (owner_q == MIO_M_CPU);
      bus_io.m1_ack   = (owner_q == MIO_M_DMA);
      bus_io.m0_rdata = rdata_q;
      bus_io.m1_rdata = rdata_q;
    end
  end

  assign bus_io.owner = owner_q;
  assign bus_io.busy  = (state_q != MIO_IDLE);

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter: two instances (WAIT_CYCLES=1/MAX_STARVE=2 and WAIT_CYCLES=3).
module tb_mio_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mio_arbiter_if ifa ();
  mio_arbiter_if ifb ();

  mio_arbiter #(.WAIT_CYCLES(1), .MAX_STARVE(2)) u_w1 (.clk(clk), .rst(rst), .bus_io(ifa));
  mio_arbiter #(.WAIT_CYCLES(3), .MAX_STARVE(8)) u_w3 (.clk(clk), .rst(rst), .bus_io(ifb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    ifa.m0_req = 0; ifa.m0_we = 0; ifa.m0_addr = '0; ifa.m0_wdata = '0;
    ifa.m1_req = 0; ifa.m1_we = 0; ifa.m1_addr = '0; ifa.m1_wdata = '0;
    ifa.d_f_mem = '0;
    ifb.m0_req = 0; ifb.m0_we = 0; ifb.m0_addr = '0; ifb.m0_wdata = '0;
    ifb.m1_req = 0; ifb.m1_we = 0; ifb.m1_addr = '0; ifb.m1_wdata = '0;
    ifb.d_f_mem = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ifa.busy, ifa.owner, ifa.wmem, ifa.rmem, ifa.m0_ack, ifa.m1_ack} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl_w1: got %b want 000000",
               {ifa.busy, ifa.owner, ifa.wmem, ifa.rmem, ifa.m0_ack, ifa.m1_ack});
    end
    checks++;
    if ({ifb.mem_a, ifb.d_t_mem} !== 64'h0 || ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus_w3: got mem_a=%h d_t_mem=%h busy=%b want 0",
               ifb.mem_a, ifb.d_t_mem, ifb.busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_addr = 32'h0000_1008; ifa.d_f_mem = 32'h1234;
    tick();
    checks++;
    if (ifa.rmem !== 1'b1 || ifa.wmem !== 1'b0 || ifa.mem_a !== 32'h0000_1008) begin
      errors++;
      $display("FAIL read_bus: got rmem=%b wmem=%b mem_a=%h want 1 0 00001008",
               ifa.rmem, ifa.wmem, ifa.mem_a);
    end
    checks++;
    if (ifa.busy !== 1'b1 || ifa.owner !== 1'b0 || ifa.m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_busy: got busy=%b owner=%b ack=%b want 1 0 0",
               ifa.busy, ifa.owner, ifa.m0_ack);
    end
    tick();
    checks++;
    if (ifa.m0_ack !== 1'b1 || ifa.m0_rdata !== 32'h1234 || ifa.m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_ack: got ack=%b rdata=%h m1_ack=%b want 1 00001234 0",
               ifa.m0_ack, ifa.m0_rdata, ifa.m1_ack);
    end
    checks++;
    if (ifa.rmem !== 1'b0 || ifa.mem_a !== 32'h0) begin
      errors++;
      $display("FAIL read_rmem_one_cycle: got rmem=%b mem_a=%h want 0 0", ifa.rmem, ifa.mem_a);
    end
    ifa.m0_req = 0;
    tick();
    checks++;
    if (ifa.busy !== 1'b0 || ifa.m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: got busy=%b ack=%b want 0 0", ifa.busy, ifa.m0_ack);
    end
  endtask

  task automatic test_single_write();
    ifb.m1_req = 1; ifb.m1_we = 1; ifb.m1_addr = 32'h0000_1000; ifb.m1_wdata = 32'h5;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ifb.mem_a !== 32'h0000_1000 || ifb.d_t_mem !== 32'h5 || ifb.rmem !== 1'b0 ||
          ifb.wmem !== (i == 3) || ifb.m1_ack !== 1'b0 || ifb.owner !== 1'b1) begin
        errors++;
        $display("FAIL write_bus_c%0d: got mem_a=%h d=%h rmem=%b wmem=%b ack=%b owner=%b want %s",
                 i, ifb.mem_a, ifb.d_t_mem, ifb.rmem, ifb.wmem, ifb.m1_ack, ifb.owner,
                 (i == 3) ? "00001000 5 0 1 0 1" : "00001000 5 0 0 0 1");
      end
    end
    tick();
    checks++;
    if (ifb.m1_ack !== 1'b1 || ifb.m0_ack !== 1'b0 || ifb.wmem !== 1'b0 || ifb.mem_a !== 0) begin
      errors++;
      $display("FAIL write_ack: got m1_ack=%b m0_ack=%b wmem=%b mem_a=%h want 1 0 0 0",
               ifb.m1_ack, ifb.m0_ack, ifb.wmem, ifb.mem_a);
    end
    ifb.m1_req = 0; ifb.m1_we = 0;
    tick();
  endtask

  task automatic test_contention();
    ifa.m0_req = 1; ifa.m0_addr = 32'hA0; ifa.m1_req = 1; ifa.m1_addr = 32'hB0;
    tick();
    checks++;
    if (ifa.owner !== 1'b0 || ifa.mem_a !== 32'hA0) begin
      errors++;
      $display("FAIL contention_first: got owner=%b mem_a=%h want 0 000000a0",
               ifa.owner, ifa.mem_a);
    end
    tick();
    ifa.m0_req = 0;
    tick();
    tick();
    checks++;
    if (ifa.owner !== 1'b1 || ifa.busy !== 1'b1 || ifa.mem_a !== 32'hB0) begin
      errors++;
      $display("FAIL contention_second: got owner=%b busy=%b mem_a=%h want 1 1 000000b0",
               ifa.owner, ifa.busy, ifa.mem_a);
    end
    tick();
    checks++;
    if (ifa.m1_ack !== 1'b1 || ifa.m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL contention_ack: got m1_ack=%b m0_ack=%b want 1 0", ifa.m1_ack, ifa.m0_ack);
    end
    ifa.m1_req = 0;
    tick();
  endtask

  task automatic test_starvation();
    logic exp_g [6];
    logic got_g [6];
    int   n = 0;
    logic prev = 1'b0;
    exp_g = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ifa.m0_req = 1; ifa.m1_req = 1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (ifa.busy && !prev) begin
        got_g[n] = ifa.owner;
        n++;
      end
      prev = ifa.busy;
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL starve_grants_timeout: got %0d grants want 6", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_g[i] !== exp_g[i]) begin
        errors++;
        $display("FAIL starve_grant%0d: got owner=%b want %b", i, got_g[i], exp_g[i]);
      end
    end
    ifa.m0_req = 0; ifa.m1_req = 0;
    repeat (4) tick();
  endtask

  task automatic test_chaining();
    int acks = 0;
    int rises = 0;
    int idles = 0;
    logic prev = 1'b0;
    ifb.m0_req = 1; ifb.m0_we = 0; ifb.m0_addr = 32'hC0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (ifb.m0_ack) acks++;
      if (ifb.busy && !prev) rises++;
      if (!ifb.busy && c <= 14) idles++;
      prev = ifb.busy;
    end
    ifb.m0_req = 0;
    checks++;
    if (acks != 3 || rises != 3) begin
      errors++;
      $display("FAIL chain_counts: got acks=%0d grants=%0d want 3 3", acks, rises);
    end
    checks++;
    if (idles != 2) begin
      errors++;
      $display("FAIL chain_idle_gaps: got %0d idle cycles want 2", idles);
    end
    repeat (2) tick();
    checks++;
    if (ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL chain_stop: got busy=%b want 0", ifb.busy);
    end
  endtask

  task automatic test_reset_mid_bus();
    int bad = 0;
    ifb.m0_req = 1; ifb.m0_we = 1; ifb.m0_addr = 32'h2000; ifb.m0_wdata = 32'hAA;
    tick();
    tick();
    checks++;
    if (ifb.busy !== 1'b1 || ifb.wmem !== 1'b0 || ifb.mem_a !== 32'h2000) begin
      errors++;
      $display("FAIL rst_pre: got busy=%b wmem=%b mem_a=%h want 1 0 00002000",
               ifb.busy, ifb.wmem, ifb.mem_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifb.mem_a !== 0 || ifb.d_t_mem !== 0 || ifb.wmem !== 0 || ifb.rmem !== 0 ||
        ifb.busy !== 0) begin
      errors++;
      $display("FAIL rst_async: got mem_a=%h d=%h wmem=%b rmem=%b busy=%b want all 0",
               ifb.mem_a, ifb.d_t_mem, ifb.wmem, ifb.rmem, ifb.busy);
    end
    ifb.m0_req = 0; ifb.m0_we = 0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (ifb.m0_ack || ifb.wmem || ifb.busy) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_dropped: got %0d cycles with ack/wmem/busy want 0", bad);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_starvation();
    test_chaining();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Two-master arbiter for the memory/IO bus: it lets the CPU (master 0) and a DMA/console engine (master 1) share the single `mem_a`/`d_t_mem`/`wmem`/`rmem`/`d_f_mem` port of the MIO decoder. It sits between the masters and the decoder. It serialises accesses through a small state machine, holds each access for a programmable number of cycles, and returns read data with a one-cycle acknowledge. Master 0 has fixed priority, and a starvation counter guarantees master 1 progress.

## Interface
- `WAIT_CYCLES`, default 1: cycles the bus is driven per access, ≥1.
- `MAX_STARVE`, default 8: consecutive arbitrations master 1 may lose before it is forced to win, ≥1.

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  **asynchronous, active-high reset**
- `m0_req`, `m1_req`  in  1  access request, held until ack
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  32  byte address
- `m0_wdata`, `m1_wdata`  in  32  write data
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `m0_rdata`, `m1_rdata`  out  32  read data, valid while ack is high
- `mem_a`  out  32  address to decoder
- `d_t_mem`  out  32  write data to decoder
- `wmem`, `rmem`  out  1  write/read strobes to decoder
- `d_f_mem`  in  32  read data from decoder
- `owner`  out  1  master currently holding the bus
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUS, ACK.
- **IDLE**
  - If no request is pending, remain in IDLE.
  - Otherwise, latch the winner into `owner`, load `cnt = WAIT_CYCLES-1`, and go to BUS.
- **Arbitration** (evaluated in IDLE only)
  - Only one master requesting: that master wins.
  - Both masters requesting: master 0 wins, unless `starve == MAX_STARVE`, in which case master 1 wins.
- **Starvation counter** `starve` (width `$clog2(MAX_STARVE+1)`):
  - Increments when master 1 requests and loses.
  - Clears to 0 when master 1 wins or when `m1_req` is low in IDLE.
  - Saturates at `MAX_STARVE`.
- **BUS**
  - `mem_a` and `d_t_mem` follow the owner's live `addr`/`wdata`.
  - `rmem = ~we` is held for all BUS cycles.
  - `wmem = we` is asserted only in the final BUS cycle (`cnt == 0`), so exactly one write strobe is issued per access.
  - `cnt` decrements each cycle.
  - At `cnt == 0`, `d_f_mem` is captured into a shared `rdata` register (writes capture as well, which is harmless), and the state goes to ACK.
- **ACK**
  - The owner's ack is high for one cycle.
  - Both `mX_rdata` outputs present `rdata`.
  - Next state is IDLE.
- Outside BUS, `mem_a`, `d_t_mem`, `wmem` and `rmem` are all 0.
- **Protocol violations**
  - A master that drops `req` or changes `addr`/`we` during BUS violates protocol.
  - The arbiter still completes the access using live inputs and still pulses ack; no abort path exists.
- **Reset** (asynchronous, any state): state = IDLE, `owner = 0`, `cnt = 0`, `starve = 0`, `rdata = 0`. All outputs go to 0 immediately. An in-flight access is dropped with no write strobe and no ack.

## Timing
- Request sampled in IDLE at edge N:
  - BUS occupies cycles N+1 … N+WAIT_CYCLES.
  - Ack is high in cycle N+WAIT_CYCLES+1.
  - IDLE resumes at N+WAIT_CYCLES+2.
- Latency from request to ack is WAIT_CYCLES+1 cycles. Peak throughput is one access per WAIT_CYCLES+2 cycles.
- A master may keep `req` high through its ack cycle to chain the next access. That request is re-arbitrated in IDLE, so there are no back-to-back grants without an IDLE cycle.
- Writes land at the decoder's negedge register inside the final BUS cycle.
- `owner` changes only on the IDLE→BUS edge. `busy` is registered from state.

## Structure
- Shared package `mio_pkg`: state enum (`MIO_IDLE`, `MIO_BUS`, `MIO_ACK`) and master index constants `MIO_M_CPU = 0`, `MIO_M_DMA = 1`.
- Single module. The arbitration/starvation decision is small enough to stay inline; no sub-module.

## Test plan
- **Reset:** `rst` pulsed mid-BUS (WAIT_CYCLES=3) → outputs 0 the same cycle, no `wmem` pulse, no ack, `busy = 0`.
- **Single read:** M0 reads `0x0000_1008` with WAIT_CYCLES=1 and `d_f_mem = 0x1234` → `rmem` high 1 cycle; `m0_ack` high 2 cycles after the request is sampled, with `m0_rdata = 0x1234`.
- **Single write:** M1 writes `0x0000_1000` = `0x5` with WAIT_CYCLES=3 → `mem_a` is stable for 3 cycles, `wmem` high only in cycle 3, `m1_ack` high in cycle 4.
- **Contention:** both masters request → M0 is granted first; M1 is granted in the next arbitration once M0 drops `req`.
- **Starvation:** M0 requests continuously, M1 requests continuously, MAX_STARVE=2 → grant sequence M0, M0, M1, M0, M0, M1…
- **Chaining:** M0 holds `req` through ack → one IDLE cycle between consecutive BUS phases; ack count equals access count.
